control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 24 ++
 rtl/control_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath signal bundle: instruction/condition in, bus-driver
// selects, register load enables and memory/ALU controls out.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        con_ff;
    logic [31:0] bus_sel;
    logic [31:0] reg_enable;
    logic [4:0]  ALU_Sel;
    logic        Read;
    logic        Write;
    logic        IncPC;
    logic        Run;
    logic [3:0]  state_out;

    modport master (
        input  IR, con_ff,
        output bus_sel, reg_enable, ALU_Sel, Read, Write, IncPC, Run, state_out
    );

    modport slave (
        output IR, con_ff,
        input  bus_sel, reg_enable, ALU_Sel, Read, Write, IncPC, Run, state_out
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer for the single-bus datapath: fetch, decode and
// execute timing steps T0..T7, with a sticky HALT that only clr leaves.
//
// state | meaning
// RST   | reset; outputs idle, Run=1
// T0    | PC -> MAR, request PC increment
// T1    | memory -> MDR
// T2    | MDR -> IR
// T3    | decode; first operand to Y (or PC to Y for br)
// T4    | ALU op into Zlow
// T5    | Zlow -> Ra (ALU/imm) or Zlow -> MAR (ld/st); br settle cycle
// T6    | ld read / st MDR load / br conditional PC load
// T7    | ld MDR -> Ra / st write strobe
// HALT  | stopped, Run=0, waits for clr
module control_sequencer (
    input  logic                      Clock,
    input  logic                      clr,
    control_sequencer_if.master       cs
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_OR   = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_SHR  = 5'd4;
    localparam logic [4:0] ALU_SHL  = 5'd5;
    localparam logic [4:0] ALU_ROR  = 5'd6;
    localparam logic [4:0] ALU_IDLE = 5'd7;
    localparam logic [4:0] ALU_ROL  = 5'd8;

    localparam logic [4:0] B_ZLOW = 5'd19;
    localparam logic [4:0] B_PC   = 5'd20;
    localparam logic [4:0] B_IR   = 5'd21;
    localparam logic [4:0] B_MDR  = 5'd22;
    localparam logic [4:0] B_MAR  = 5'd23;
    localparam logic [4:0] B_Y    = 5'd24;
    localparam logic [4:0] B_COUT = 5'd25;

    logic [3:0]  state, state_nxt;
    logic [4:0]  opcode;
    logic [4:0]  ra, rb, rc;
    logic        is_alu, is_imm, is_ld, is_st, is_br, is_halt;
    logic [4:0]  alu_code;
    logic [31:0] bus_sel, reg_enable;
    logic [4:0]  alu_sel;
    logic        rd, wr, inc_pc;
    logic        unused_ir;

    function automatic logic [31:0] sel(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

    assign opcode    = cs.IR[31:27];
    assign ra        = {1'b0, cs.IR[26:23]};
    assign rb        = {1'b0, cs.IR[22:19]};
    assign rc        = {1'b0, cs.IR[18:15]};
    assign unused_ir = ^cs.IR[14:0];

    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_br   = (opcode == OP_BR);
    assign is_halt = (opcode == OP_HALT);

    always_comb begin
        is_alu   = 1'b0;
        is_imm   = 1'b0;
        alu_code = ALU_IDLE;
        case (opcode)
            OP_ADD:  begin is_alu = 1'b1; alu_code = ALU_ADD; end
            OP_SUB:  begin is_alu = 1'b1; alu_code = ALU_SUB; end
            OP_SHR:  begin is_alu = 1'b1; alu_code = ALU_SHR; end
            OP_SHL:  begin is_alu = 1'b1; alu_code = ALU_SHL; end
            OP_ROR:  begin is_alu = 1'b1; alu_code = ALU_ROR; end
            OP_ROL:  begin is_alu = 1'b1; alu_code = ALU_ROL; end
            OP_AND:  begin is_alu = 1'b1; alu_code = ALU_AND; end
            OP_OR:   begin is_alu = 1'b1; alu_code = ALU_OR;  end
            OP_ADDI, OP_LDI: begin is_imm = 1'b1; alu_code = ALU_ADD; end
            OP_ANDI: begin is_imm = 1'b1; alu_code = ALU_AND; end
            OP_ORI:  begin is_imm = 1'b1; alu_code = ALU_OR;  end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clr) state <= S_RST;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_RST;
        case (state)
            S_RST:  state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                if (is_halt)
                    state_nxt = S_HALT;
                else if (is_alu || is_imm || is_ld || is_st || is_br)
                    state_nxt = S_T4;
                else
                    state_nxt = S_T0;
            end
            S_T4:   state_nxt = S_T5;
            S_T5:   state_nxt = (is_ld || is_st || is_br) ? S_T6 : S_T0;
            S_T6:   state_nxt = (is_ld || is_st) ? S_T7 : S_T0;
            S_T7:   state_nxt = S_T0;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    // con_ff is itself a datapath flip-flop, so the T6 branch decode stays registered.
    always_comb begin
        bus_sel    = '0;
        reg_enable = '0;
        alu_sel    = ALU_IDLE;
        rd         = 1'b0;
        wr         = 1'b0;
        inc_pc     = 1'b0;
        case (state)
            S_T0: begin
                bus_sel    = sel(B_PC);
                reg_enable = sel(B_MAR);
                inc_pc     = 1'b1;
            end
            S_T1: begin
                rd         = 1'b1;
                reg_enable = sel(B_MDR);
            end
            S_T2: begin
                bus_sel    = sel(B_MDR);
                reg_enable = sel(B_IR);
            end
            S_T3: begin
                if (is_alu || is_imm || is_ld || is_st) begin
                    bus_sel    = sel(rb);
                    reg_enable = sel(B_Y);
                end else if (is_br) begin
                    bus_sel    = sel(B_PC);
                    reg_enable = sel(B_Y);
                end
            end
            S_T4: begin
                if (is_alu) begin
                    bus_sel    = sel(rc);
                    alu_sel    = alu_code;
                    reg_enable = sel(B_ZLOW);
                end else if (is_imm) begin
                    bus_sel    = sel(B_COUT);
                    alu_sel    = alu_code;
                    reg_enable = sel(B_ZLOW);
                end else if (is_ld || is_st || is_br) begin
                    bus_sel    = sel(B_COUT);
                    alu_sel    = ALU_ADD;
                    reg_enable = sel(B_ZLOW);
                end
            end
            S_T5: begin
                if (is_alu || is_imm) begin
                    bus_sel    = sel(B_ZLOW);
                    reg_enable = sel(ra);
                end else if (is_ld || is_st) begin
                    bus_sel    = sel(B_ZLOW);
                    reg_enable = sel(B_MAR);
                end
            end
            S_T6: begin
                if (is_ld) begin
                    rd         = 1'b1;
                    reg_enable = sel(B_MDR);
                end else if (is_st) begin
                    bus_sel    = sel(ra);
                    reg_enable = sel(B_MDR);
                end else if (is_br && cs.con_ff) begin
                    bus_sel    = sel(B_ZLOW);
                    reg_enable = sel(B_PC);
                end
            end
            S_T7: begin
                if (is_ld) begin
                    bus_sel    = sel(B_MDR);
                    reg_enable = sel(ra);
                end else if (is_st) begin
                    wr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign cs.bus_sel    = bus_sel;
    assign cs.reg_enable = reg_enable;
    assign cs.ALU_Sel    = alu_sel;
    assign cs.Read       = rd;
    assign cs.Write      = wr;
    assign cs.IncPC      = inc_pc;
    assign cs.Run        = (state != S_HALT);
    assign cs.state_out  = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: each instruction's expected
// per-cycle control word list is built from the opcode class and compared cycle by cycle.
module tb_control_sequencer;

    logic Clock = 1'b0;
    logic clr;

    control_sequencer_if cs_if();

    control_sequencer dut (
        .Clock (Clock),
        .clr   (clr),
        .cs    (cs_if)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int K_ALU  = 0;
    localparam int K_IMM  = 1;
    localparam int K_LD   = 2;
    localparam int K_ST   = 3;
    localparam int K_BR   = 4;
    localparam int K_HALT = 5;
    localparam int K_NOP  = 6;

    typedef struct {
        logic [31:0] bus;
        logic [31:0] en;
        logic [4:0]  alu;
        bit          rd;
        bit          wr;
        bit          inc;
    } step_t;

    step_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic step_t idle();
        step_t s;
        s.bus = '0; s.en = '0; s.alu = 5'd7;
        s.rd = 1'b0; s.wr = 1'b0; s.inc = 1'b0;
        return s;
    endfunction

    // One register transfer: src drives the bus, dst loads (negative = none).
    function automatic step_t mv(input int src, input int dst);
        step_t s = idle();
        if (src >= 0) s.bus = 32'd1 << src;
        if (dst >= 0) s.en  = 32'd1 << dst;
        return s;
    endfunction

    function automatic int kind_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: return K_ALU;
            5'b01011, 5'b01100, 5'b01101, 5'b00001: return K_IMM;
            5'b00000: return K_LD;
            5'b00010: return K_ST;
            5'b10010: return K_BR;
            5'b11011: return K_HALT;
            default:  return K_NOP;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00100:                     return 5'd1;
            5'b01010, 5'b01101:           return 5'd2;
            5'b01001, 5'b01100:           return 5'd3;
            5'b00101:                     return 5'd4;
            5'b00110:                     return 5'd5;
            5'b00111:                     return 5'd6;
            5'b01000:                     return 5'd8;
            default:                      return 5'd0;
        endcase
    endfunction

    task automatic build(input logic [31:0] ir, input bit con);
        step_t s;
        int    k  = kind_of(ir[31:27]);
        int    ra = int'(ir[26:23]);
        int    rb = int'(ir[22:19]);
        int    rc = int'(ir[18:15]);
        exp_q.delete();
        s = mv(20, 23); s.inc = 1'b1; exp_q.push_back(s);
        s = mv(-1, 22); s.rd = 1'b1;  exp_q.push_back(s);
        exp_q.push_back(mv(22, 21));
        case (k)
            K_ALU, K_IMM: begin
                exp_q.push_back(mv(rb, 24));
                s = mv((k == K_IMM) ? 25 : rc, 19); s.alu = alu_of(ir[31:27]);
                exp_q.push_back(s);
                exp_q.push_back(mv(19, ra));
            end
            K_LD, K_ST: begin
                exp_q.push_back(mv(rb, 24));
                s = mv(25, 19); s.alu = 5'd0; exp_q.push_back(s);
                exp_q.push_back(mv(19, 23));
                if (k == K_LD) begin
                    s = mv(-1, 22); s.rd = 1'b1; exp_q.push_back(s);
                    exp_q.push_back(mv(22, ra));
                end else begin
                    exp_q.push_back(mv(ra, 22));
                    s = idle(); s.wr = 1'b1; exp_q.push_back(s);
                end
            end
            K_BR: begin
                exp_q.push_back(mv(20, 24));
                s = mv(25, 19); s.alu = 5'd0; exp_q.push_back(s);
                exp_q.push_back(idle());
                exp_q.push_back(con ? mv(19, 20) : idle());
            end
            default: exp_q.push_back(idle());
        endcase
    endtask

    task automatic check_step(input string tag, input step_t e, input logic [3:0] st, input bit run);
        chk({tag, ".bus_sel"},    cs_if.bus_sel,    e.bus);
        chk({tag, ".reg_enable"}, cs_if.reg_enable, e.en);
        chk({tag, ".ctl"},
            {19'd0, cs_if.state_out, cs_if.ALU_Sel, cs_if.Read, cs_if.Write, cs_if.IncPC, cs_if.Run},
            {19'd0, st, e.alu, e.rd, e.wr, e.inc, run});
    endtask

    // Starts at the negedge where the DUT sits in T0; ends at the negedge of the last checked step.
    task automatic run_instr(input logic [31:0] ir, input bit con, input string tag, input int n_steps);
        int n;
        build(ir, con);
        cs_if.con_ff = con;
        n = (n_steps < 0 || n_steps > exp_q.size()) ? exp_q.size() : n_steps;
        for (int i = 0; i < n; i++) begin
            check_step($sformatf("%s.T%0d", tag, i), exp_q[i], 4'(i + 1), 1'b1);
            if (i == 2) cs_if.IR = ir;
            if (i != n - 1) @(negedge Clock);
        end
    endtask

    task automatic full(input string tag, input logic [31:0] ir, input bit con);
        run_instr(ir, con, tag, -1);
        @(negedge Clock);
        chk({tag, ".ret_t0"}, {28'd0, cs_if.state_out}, 32'd1);
    endtask

    function automatic logic [31:0] rand_ir(input logic [4:0] op);
        logic [26:0] r;
        r = 27'($urandom());
        return {op, r};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] op;
        clr          = 1'b1;
        cs_if.IR     = 32'd0;
        cs_if.con_ff = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        check_step("rst", idle(), 4'd0, 1'b1);
        clr = 1'b0;
        @(negedge Clock);

        full("and_dir", 32'h4A920000, 1'b0);
        full("ld_dir",  32'h00800005, 1'b1);
        full("br_c0",   rand_ir(5'b10010), 1'b0);
        full("br_c1",   rand_ir(5'b10010), 1'b1);
        full("st_dir",  rand_ir(5'b00010), 1'b0);
        full("ldi_dir", rand_ir(5'b00001), 1'b1);

        for (int i = 0; i < 32; i++) begin
            if (i != 27) full($sformatf("op%0d", i), rand_ir(5'(i)), 1'($urandom()));
        end

        for (int i = 0; i < 250; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            full($sformatf("rnd%0d_op%0d", i, op), rand_ir(op), 1'($urandom()));
        end

        run_instr(32'hD8000000, 1'b0, "halt", -1);
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            check_step($sformatf("halt.hold%0d", i), idle(), 4'd9, 1'b0);
        end
        clr = 1'b1;
        @(negedge Clock);
        check_step("halt.clr", idle(), 4'd0, 1'b1);
        clr = 1'b0;
        @(negedge Clock);
        chk("halt.t0", {28'd0, cs_if.state_out}, 32'd1);

        run_instr(rand_ir(5'b00011), 1'b0, "abort_alu", 5);
        clr = 1'b1;
        @(negedge Clock);
        check_step("abort_alu.rst", idle(), 4'd0, 1'b1);
        clr = 1'b0;
        @(negedge Clock);
        chk("abort_alu.t0", {28'd0, cs_if.state_out}, 32'd1);

        run_instr(32'h00800005, 1'b0, "abort_ld", 7);
        clr = 1'b1;
        @(negedge Clock);
        check_step("abort_ld.rst", idle(), 4'd0, 1'b1);
        @(negedge Clock);
        check_step("abort_ld.rst_hold", idle(), 4'd0, 1'b1);
        clr = 1'b0;
        @(negedge Clock);
        chk("abort_ld.t0", {28'd0, cs_if.state_out}, 32'd1);

        full("post_abort", 32'h4A920000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
